// File: rtl/alu_uart_ctrl.sv
// Sequencer between the UART byte interface and a combinational ALU: collects
// operand A, operand B and opcode bytes, captures the ALU result and sends it back.
module alu_uart_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               err_q, err_d;
  logic [NB_OP-1:0]   rx_op;
  logic               op_legal;
  logic               expired;

  assign rx_op   = i_rx_data[NB_OP-1:0];
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    op_legal = 1'b0;
    case (rx_op)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b000011, 6'b000010: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      WAIT_A: begin
        cnt_d = '0;
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        // An arriving byte takes priority over a simultaneous expiry.
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          cnt_d   = '0;
          state_d = WAIT_OP;
        end else if (expired) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          cnt_d = '0;
          if (op_legal) begin
            alu_op_d = rx_op;
            state_d  = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_A;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXEC: begin
        // Operands were registered last cycle, so the ALU output has settled.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = SEND;
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          cnt_d   = '0;
          state_d = WAIT_A;
        end else if (expired) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_A;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != WAIT_A);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a small behavioural ALU closing the loop.
module tb_alu_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_err;

  int total = 0;
  int bad   = 0;

  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
    .i_alu_result(i_alu_result),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (o_alu_op)
      6'b100000: i_alu_result = o_alu_a + o_alu_b;
      6'b100010: i_alu_result = o_alu_a - o_alu_b;
      6'b100100: i_alu_result = o_alu_a & o_alu_b;
      6'b100101: i_alu_result = o_alu_a | o_alu_b;
      6'b100110: i_alu_result = o_alu_a ^ o_alu_b;
      6'b100111: i_alu_result = ~(o_alu_a | o_alu_b);
      6'b000011: i_alu_result = $signed(o_alu_a) >>> o_alu_b;
      6'b000010: i_alu_result = o_alu_a >> o_alu_b;
      default:   i_alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drives one rx byte; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  // Full frame: three bytes, result check, tx_done handshake.
  task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
    int starts;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check({tag, "_a"}, o_alu_a, a);
    check({tag, "_b"}, o_alu_b, b);
    check({tag, "_op"}, o_alu_op, op[5:0]);
    check({tag, "_start_exec"}, o_tx_start, 1'b0);
    @(negedge clk);
    check({tag, "_start_send"}, o_tx_start, 1'b1);
    check({tag, "_data"}, o_tx_data, exp);
    starts = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_tx_start) starts++;
    end
    check({tag, "_single_start"}, starts, 0);
    check({tag, "_data_held"}, o_tx_data, exp);
    check({tag, "_busy_tx"}, o_busy, 1'b1);
    pulse_tx_done();
    check({tag, "_busy_done"}, o_busy, 1'b0);
  endtask

  initial begin
    int starts;
    int seen_err;
    reset     = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", o_alu_a, 8'h00);
    check("rst_b", o_alu_b, 8'h00);
    check("rst_op", o_alu_op, 6'h00);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_start", o_tx_start, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    do_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    do_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    do_frame("nor", 8'hF0, 8'h0F, 8'h27, 8'h00);
    do_frame("xor_hibits", 8'h5A, 8'h0F, 8'hE6, 8'h55);

    // Illegal opcode 111111
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h3F);
    check("ill_err", o_err, 1'b1);
    check("ill_busy", o_busy, 1'b0);
    check("ill_op_kept", o_alu_op, 6'b100110);
    starts = 0;
    @(negedge clk);
    check("ill_err_pulse", o_err, 1'b0);
    repeat (5) begin
      @(negedge clk);
      if (o_tx_start) starts++;
    end
    check("ill_no_start", starts, 0);

    // Inter-byte timeout in WAIT_B
    send_byte(8'h05);
    repeat (99) @(negedge clk);
    check("to_err_early", o_err, 1'b0);
    check("to_busy_early", o_busy, 1'b1);
    @(negedge clk);
    check("to_err", o_err, 1'b1);
    check("to_busy", o_busy, 1'b0);
    check("to_a_kept", o_alu_a, 8'h05);
    @(negedge clk);
    check("to_err_pulse", o_err, 1'b0);
    do_frame("after_to", 8'h07, 8'h02, 8'h22, 8'h05);

    // Extra byte during WAIT_TX, tx_done withheld
    send_byte(8'h0E);
    send_byte(8'h0B);
    send_byte(8'h24);
    @(negedge clk);
    check("wtx_start", o_tx_start, 1'b1);
    check("wtx_data", o_tx_data, 8'h0A);
    send_byte(8'hAA);
    check("wtx_a_kept", o_alu_a, 8'h0E);
    check("wtx_busy", o_busy, 1'b1);
    starts   = 0;
    seen_err = 0;
    for (int i = 0; i < 150 && seen_err == 0; i++) begin
      @(negedge clk);
      if (o_tx_start) starts++;
      if (o_err) seen_err = 1;
    end
    check("wtx_timeout_err", seen_err, 1);
    check("wtx_no_restart", starts, 0);
    check("wtx_idle", o_busy, 1'b0);
    check("wtx_data_kept", o_tx_data, 8'h0A);

    // Asynchronous reset in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    check("ar_busy_pre", o_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("ar_a", o_alu_a, 8'h00);
    check("ar_b", o_alu_b, 8'h00);
    check("ar_op", o_alu_op, 6'h00);
    check("ar_tx_data", o_tx_data, 8'h00);
    check("ar_busy", o_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h20);
    starts = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_tx_start) starts++;
    end
    check("ar_no_start", starts, 0);
    check("ar_a_new", o_alu_a, 8'h20);
    check("ar_busy_wait_b", o_busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
Sequencer between the UART core (rx/tx byte interface plus baud-tick datapath) and the combinational ALU. It collects three received bytes in order (operand A, operand B, opcode), drives the ALU, captures the result and launches one UART transmission of it. It also handles an inter-byte timeout and rejects unknown opcodes, so a corrupted frame never leaves the link stuck.

Parameters:
NB_DATA, 8, width of operands, result and UART data bytes
NB_OP, 6, opcode width (low NB_OP bits of the third received byte)
TIMEOUT_CYC, 5000000, clk cycles allowed between bytes, and for tx completion, before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_rx_data  in  NB_DATA  byte from UART receiver, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, receiver has a new byte
i_tx_done  in  1  one-cycle pulse, transmitter finished stop bit
i_alu_result  in  NB_DATA  combinational ALU output for current o_alu_a/b/op
o_alu_a  out  NB_DATA  operand A register
o_alu_b  out  NB_DATA  operand B register
o_alu_op  out  NB_OP  opcode register
o_tx_data  out  NB_DATA  byte to transmit, held stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle pulse, start transmission
o_busy  out  1  high in every state except WAIT_A
o_err  out  1  one-cycle pulse on timeout or invalid opcode

Behaviour:
- Reset (async, active-high): state=WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_start=0, o_busy=0, o_err=0; timeout counter=0. Reset asserted mid-frame or mid-transmission aborts immediately; no o_tx_start after release until a fresh three-byte frame.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_alu_a<=i_rx_data, go to WAIT_B. No timeout in this state.
- WAIT_B: on i_rx_done, o_alu_b<=i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done:
  - if i_rx_data[NB_OP-1:0] is a legal opcode, o_alu_op<=i_rx_data[NB_OP-1:0] and go to EXEC;
  - otherwise pulse o_err, leave o_alu_op unchanged and go to WAIT_A.
  - Upper byte bits are ignored.
- Legal opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- EXEC: exactly one cycle. o_tx_data<=i_alu_result (ALU settles on registered inputs), go to SEND.
- SEND: o_tx_start=1 for exactly this one cycle, go to WAIT_TX.
- WAIT_TX: on i_tx_done go to WAIT_A.
- Latency: opcode i_rx_done edge to o_tx_start high is 2 cycles (WAIT_OP -> EXEC -> SEND).
- Timeout counter:
  - cleared on every state change and on every accepted i_rx_done;
  - increments each cycle in WAIT_B, WAIT_OP and WAIT_TX.
  - On reaching TIMEOUT_CYC-1: pulse o_err, go to WAIT_A. Operand registers are kept, not cleared.
- i_rx_done during EXEC, SEND or WAIT_TX: byte discarded, no state effect. The host must not send the next frame before the result byte.
- i_tx_done outside WAIT_TX: ignored.
- i_rx_done and timeout expiry in the same cycle: the byte wins and the counter clears.
- o_busy is decoded from the state (registered state, no combinational input path). All other outputs are registered.

Test Plan:
- Reset then rx bytes 0x05, 0x03, 0x20 with ALU model ADD -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'b100000; single o_tx_start pulse 2 cycles after third i_rx_done; o_tx_data=0x08 held until i_tx_done; o_busy returns 0.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; then 0xF0, 0x0F, 0x27 (NOR) -> 0x00; back-to-back frames separated only by i_tx_done.
- Bytes 0x10, 0x20, 0x3F (illegal opcode 111111) -> o_err one pulse, no o_tx_start, state WAIT_A, o_alu_op keeps its previous value.
- Byte 0x05, then no input for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC=100) -> o_err at cycle 100, o_busy=0; next three bytes form a new, correct frame.
- Extra i_rx_done (0xAA) during WAIT_TX, and i_tx_done withheld for 100 cycles -> extra byte ignored; timeout o_err; no second o_tx_start.
- reset pulsed while in WAIT_OP (after two bytes) -> all outputs 0 immediately (asynchronous); a following single opcode byte does not trigger tx.
